design_interface: RTL and testbench
===================================

Name: design_interface

Overview:
- Time-multiplexed driver for a 4-digit, common-anode, seven-segment display.
- Takes a 16-bit value as four hex nibbles plus four decimal-point flags.
- Scans one digit at a time and drives active-low anode and segment lines.
- Sits between the datapath and the board's 8-position display; the upper 4 positions are always blanked.

Parameters:
- REFRESH_BITS, 8, width of the refresh prescaler; each digit is lit for 2^REFRESH_BITS clocks (256 clocks = 51.2 us at 5 MHz; full scan 1024 clocks).

Ports:
- clock  in  1  system clock, rising-edge, 5 MHz nominal
- reset  in  1  asynchronous, active-low reset
- value  in  16  display data; value[4i+3:4i] shown on digit i, digit 0 rightmost
- dots  in  4  decimal-point request, active-high; dots[i] lights the DP of digit i
- selector  out  4  one-hot, active-high index of the currently lit digit
- digit  out  8  anode enables, active-low; digit[3:0] = ~selector, digit[7:4] always 1
- segment  out  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, scan index=0, selector=4'b0000, digit=8'hFF, segment=8'hFF (all dark). Reset has priority mid-scan.
- Prescaler: free-running REFRESH_BITS-bit counter incrementing every clock, wrapping at all-ones.
- Scan index: 2-bit, increments when the prescaler wraps; order 0,1,2,3,0,...
- All outputs are registered and update every clock from the current scan index and current inputs.
  - First clock after reset release: digit 0 is lit.
  - A change on value or dots appears on segment one clock later, without waiting for a digit change.
- Exactly one of digit[3:0] is low at any time outside reset.
- Segment encoding, segment[6:0] active-low g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- segment[7] = ~dots[index].
- No ghosting: anode and cathode change on the same clock edge, both registered.
- Inputs need no synchronisation; they are treated as synchronous to clock.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: digit i (i=3..1) is blanked (segment=8'hFF, anode still driven per scan) when value[15:4i]==0 and dots[i]==0. Digit 0 is always shown. Example: value=0x0034 shows only "34".
- Undefined: all four digits always show their hex nibble, including leading zeros.

Test Plan:
- Reset: hold reset=0 for 500 clocks -> digit=8'hFF, segment=8'hFF, selector=0000. Release -> one clock later digit=8'hFE, selector=0001.
- Scan timing: value=0x1234, dots=0 -> each digit lit exactly 256 clocks; anode sequence FE,FD,FB,F7,FE; digit[7:4] always 1; selector always one-hot.
- Decode with dots: value=0x1234, dots=4'b0101 -> segment per digit: d0=0x19, d1=0xB0, d2=0x24, d3=0xF9.
- Hex letters, all dots: value=0xF4A8, dots=4'b1111 -> d0=0x00, d1=0x08, d2=0x19, d3=0x0E.
- Mid-digit change: switch value 0x1234->0xF4A8 while digit 0 is lit -> segment goes 0x99->0x80 one clock later with no change to digit. Assert reset mid-scan -> outputs go dark immediately, without waiting for a clock edge.
- Full table: sweep all 16 nibbles on digit 0 -> segment[6:0] matches the encoding table. With LEADING_ZERO_BLANK_EN defined, value=0x0034 -> d2, d3 give 0xFF.

Source files
------------

// File: rtl/design_interface_if.sv
// -----------------------------------------------------------------------------
// design_interface_if
//   Bundle between the datapath and the 4-digit seven-segment scan driver.
//
//   Signals:
//     value    [15:0]  display data, nibble i shown on digit i (digit 0 rightmost)
//     dots     [3:0]   decimal-point requests, active-high, one per digit
//     selector [3:0]   one-hot, active-high index of the lit digit
//     digit    [7:0]   anode enables, active-low; [7:4] always high
//     segment  [7:0]   cathodes, active-low, {dp,g,f,e,d,c,b,a}
//
//   Modports:
//     master  datapath side: drives value/dots, observes display lines
//     slave   display driver side: consumes value/dots, drives display lines
// -----------------------------------------------------------------------------
interface design_interface_if;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  selector;
    logic [7:0]  digit;
    logic [7:0]  segment;

    modport master (
        output value,
        output dots,
        input  selector,
        input  digit,
        input  segment
    );

    modport slave (
        input  value,
        input  dots,
        output selector,
        output digit,
        output segment
    );
endinterface

// File: rtl/design_interface.sv
// -----------------------------------------------------------------------------
// design_interface
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   A free-running prescaler advances a 2-bit scan index; every clock the
//   anode, selector and cathode lines are re-registered from the current scan
//   index and the current value/dots, so anode and cathode always switch on
//   the same edge and input changes show up one clock later.
//
//   Parameters:
//     REFRESH_BITS  prescaler width; each digit is lit for 2**REFRESH_BITS clocks
//
//   Ports:
//     clock  in   system clock, rising edge
//     reset  in   asynchronous reset, active low (all outputs dark)
//     bus    slave side of design_interface_if (value, dots in;
//            selector, digit, segment out)
//
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, digits 3..1 are blanked while every
//                            nibble from that digit upward is zero and the
//                            digit's own dot is off. Digit 0 is always shown.
// -----------------------------------------------------------------------------

// Per-digit cathode pattern: hex decode plus decimal point, or fully dark.
module design_interface_digit (
    input  logic [3:0] nibble,
    input  logic       dot,
    input  logic       blank,
    output logic [7:0] pattern
);
    logic [6:0] seg7;

    // Active-low g..a
    always_comb begin
        seg7 = 7'h7F;
        case (nibble)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    end

    assign pattern = blank ? 8'hFF : {~dot, seg7};
endmodule

module design_interface #(
    parameter int REFRESH_BITS = 8
) (
    input  logic               clock,
    input  logic               reset,
    design_interface_if.slave  bus
);
    localparam int NUM_DIGITS = 4;

    logic [REFRESH_BITS-1:0]          prescaler;
    logic [1:0]                       scan_idx;
    logic [NUM_DIGITS-1:0][7:0]       pattern;
    logic [NUM_DIGITS-1:0]            sel_next;

    logic [3:0]                       selector_q;
    logic [7:0]                       digit_q;
    logic [7:0]                       segment_q;

    // Decode every digit in parallel; the scan index just picks one.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic blank;

        if (gi == 0) begin : g_first
            // The rightmost digit always shows something, even for value 0.
            assign blank = 1'b0;
        end else begin : g_upper
`ifdef LEADING_ZERO_BLANK_EN
            // A lit dot keeps the digit visible even when it is a leading zero.
            assign blank = (bus.value[15:4*gi] == '0) && !bus.dots[gi];
`else
            assign blank = 1'b0;
`endif
        end

        design_interface_digit u_digit (
            .nibble  (bus.value[4*gi+3:4*gi]),
            .dot     (bus.dots[gi]),
            .blank   (blank),
            .pattern (pattern[gi])
        );
    end

    assign sel_next = 4'b0001 << scan_idx;

    // Scan counter: index steps when the prescaler is about to wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            scan_idx  <= 2'd0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (&prescaler)
                scan_idx <= scan_idx + 1'b1;
        end
    end

    // Anodes and cathodes are registered together from the same index so a
    // digit never briefly shows its neighbour's pattern.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            selector_q <= 4'b0000;
            digit_q    <= 8'hFF;
            segment_q  <= 8'hFF;
        end else begin
            selector_q <= sel_next;
            digit_q    <= {4'hF, ~sel_next};
            segment_q  <= pattern[scan_idx];
        end
    end

    assign bus.selector = selector_q;
    assign bus.digit    = digit_q;
    assign bus.segment  = segment_q;
endmodule

// File: tb/tb_design_interface.sv
`timescale 1ns/1ps
module tb_design_interface;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;   // clocks since last reset release

    // Hand-entered encoding table, active-low g..a
    logic [6:0] enc [16];

    design_interface_if bus ();

    design_interface #(.REFRESH_BITS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #100 clock = ~clock;   // 5 MHz

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    function automatic int cur_idx();
        return ((cyc - 1) >> 8) & 3;
    endfunction

    function automatic int cur_pos();
        return (cyc - 1) & 255;
    endfunction

    // Advance until digit i is lit with plenty of its slot remaining.
    task automatic goto_digit(input int i);
        int guard = 0;
        while (!(cyc >= 1 && cur_idx() == i && cur_pos() <= 200) && guard < 2000) begin
            tick(1);
            guard++;
        end
        if (guard >= 2000) begin
            n_total++;
            $display("FAIL goto_digit%0d: timeout after %0d clocks", i, guard);
        end
    endtask

    task automatic test_reset();
        bus.value = 16'h0000;
        bus.dots  = 4'b0000;
        reset     = 1'b0;
        tick(500);
        n_total++;
        if (bus.digit !== 8'hFF) $display("FAIL reset_digit: got %h expected ff", bus.digit);
        else n_pass++;
        n_total++;
        if (bus.segment !== 8'hFF) $display("FAIL reset_segment: got %h expected ff", bus.segment);
        else n_pass++;
        n_total++;
        if (bus.selector !== 4'b0000) $display("FAIL reset_selector: got %b expected 0000", bus.selector);
        else n_pass++;
        reset = 1'b1;
        cyc   = 0;
        tick(1);
        n_total++;
        if (bus.digit !== 8'hFE) $display("FAIL release_digit: got %h expected fe", bus.digit);
        else n_pass++;
        n_total++;
        if (bus.selector !== 4'b0001) $display("FAIL release_selector: got %b expected 0001", bus.selector);
        else n_pass++;
        n_total++;
        if (bus.segment !== 8'hC0) $display("FAIL release_segment: got %h expected c0", bus.segment);
        else n_pass++;
    endtask

    // Runs from the first clock after reset release for a full scan plus one.
    task automatic test_scan_timing();
        logic [7:0] exp_seq [5];
        logic [7:0] seq [5];
        int         runlen [5];
        int         nseq;
        logic [7:0] prev;
        logic [3:0] exp_sel;
        exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFD; exp_seq[2] = 8'hFB;
        exp_seq[3] = 8'hF7; exp_seq[4] = 8'hFE;
        for (int j = 0; j < 5; j++) begin
            seq[j] = 8'h00;
            runlen[j] = 0;
        end
        bus.value = 16'h1234;
        bus.dots  = 4'b0000;
        nseq = 0;
        prev = 8'h00;
        // cyc is 1 here; walk through clock 1025
        while (cyc <= 1025) begin
            exp_sel = 4'b0001 << cur_idx();
            n_total++;
            if (bus.selector !== exp_sel || bus.digit !== {4'hF, ~exp_sel})
                $display("FAIL scan_cyc%0d: got sel=%b digit=%h expected sel=%b digit=%h",
                         cyc, bus.selector, bus.digit, exp_sel, {4'hF, ~exp_sel});
            else n_pass++;
            if (bus.digit !== prev) begin
                if (nseq < 5) seq[nseq] = bus.digit;
                nseq++;
                prev = bus.digit;
            end
            if (nseq >= 1 && nseq <= 5) runlen[nseq-1]++;
            tick(1);
        end
        for (int j = 0; j < 5; j++) begin
            n_total++;
            if (seq[j] !== exp_seq[j]) $display("FAIL anode_seq%0d: got %h expected %h", j, seq[j], exp_seq[j]);
            else n_pass++;
        end
        for (int j = 0; j < 4; j++) begin
            n_total++;
            if (runlen[j] != 256) $display("FAIL dwell_digit%0d: got %0d expected 256", j, runlen[j]);
            else n_pass++;
        end
    endtask

    task automatic check_digits(input string name, input logic [15:0] v, input logic [3:0] d,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        bus.value = v;
        bus.dots  = d;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            goto_digit(i);
            n_total++;
            if (bus.segment !== exp[i])
                $display("FAIL %s_d%0d: got %h expected %h", name, i, bus.segment, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_decode_dots();
        check_digits("dots0101", 16'h1234, 4'b0101, 8'h19, 8'hB0, 8'h24, 8'hF9);
    endtask

    task automatic test_hex_letters();
        check_digits("hex_f4a8", 16'hF4A8, 4'b1111, 8'h00, 8'h08, 8'h19, 8'h0E);
    endtask

    task automatic test_mid_digit_change();
        bus.value = 16'h1234;
        bus.dots  = 4'b0000;
        tick(1);
        goto_digit(0);
        n_total++;
        if (bus.segment !== 8'h99) $display("FAIL mid_before: got %h expected 99", bus.segment);
        else n_pass++;
        bus.value = 16'hF4A8;
        tick(1);
        n_total++;
        if (bus.segment !== 8'h80) $display("FAIL mid_after_seg: got %h expected 80", bus.segment);
        else n_pass++;
        n_total++;
        if (bus.digit !== 8'hFE) $display("FAIL mid_after_digit: got %h expected fe", bus.digit);
        else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        bus.value = 16'h1234;
        bus.dots  = 4'b1111;
        tick(1);
        goto_digit(2);
        #20 reset = 1'b0;
        #1;
        n_total++;
        if (bus.digit !== 8'hFF || bus.segment !== 8'hFF || bus.selector !== 4'b0000)
            $display("FAIL async_reset: got digit=%h seg=%h sel=%b expected ff ff 0000",
                     bus.digit, bus.segment, bus.selector);
        else n_pass++;
        tick(3);
        n_total++;
        if (bus.digit !== 8'hFF || bus.segment !== 8'hFF)
            $display("FAIL reset_hold: got digit=%h seg=%h expected ff ff", bus.digit, bus.segment);
        else n_pass++;
        reset = 1'b1;
        cyc   = 0;
        tick(1);
        n_total++;
        // digit 0 nibble 4 with its dot on
        if (bus.digit !== 8'hFE || bus.segment !== 8'h19)
            $display("FAIL restart: got digit=%h seg=%h expected fe 19", bus.digit, bus.segment);
        else n_pass++;
    endtask

    task automatic test_full_table();
        logic [7:0] exp;
        bus.value = 16'h0000;
        bus.dots  = 4'b0000;
        tick(1);
        goto_digit(0);
        for (int n = 0; n < 16; n++) begin
            bus.value = 16'(n);
            tick(1);
            exp = {1'b1, enc[n]};
            n_total++;
            if (bus.segment !== exp || bus.digit !== 8'hFE)
                $display("FAIL table_%h: got seg=%h digit=%h expected seg=%h digit=fe",
                         n[3:0], bus.segment, bus.digit, exp);
            else n_pass++;
        end
    endtask

    task automatic test_leading_zero();
`ifdef LEADING_ZERO_BLANK_EN
        check_digits("lzb_0034", 16'h0034, 4'b0000, 8'h99, 8'hB0, 8'hFF, 8'hFF);
        check_digits("lzb_dot3", 16'h0034, 4'b1000, 8'h99, 8'hB0, 8'hFF, 8'h40);
`else
        check_digits("lz_0034", 16'h0034, 4'b0000, 8'h99, 8'hB0, 8'hC0, 8'hC0);
`endif
    endtask

    initial begin
        enc[0]  = 7'h40; enc[1]  = 7'h79; enc[2]  = 7'h24; enc[3]  = 7'h30;
        enc[4]  = 7'h19; enc[5]  = 7'h12; enc[6]  = 7'h02; enc[7]  = 7'h78;
        enc[8]  = 7'h00; enc[9]  = 7'h10; enc[10] = 7'h08; enc[11] = 7'h03;
        enc[12] = 7'h46; enc[13] = 7'h21; enc[14] = 7'h06; enc[15] = 7'h0E;

        test_reset();
        test_scan_timing();
        test_decode_dots();
        test_hex_letters();
        test_mid_digit_change();
        test_reset_mid_scan();
        test_full_table();
        test_leading_zero();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
